// File: rtl/mul_unit.sv
// Iterative shift-add multiplier: one partial product per clock, fixed WIDTH-cycle latency.
// Returns the low WIDTH bits of the product, which are correct for both signed and unsigned operands.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int            CW     = $clog2(WIDTH) + 1;
  localparam logic [2:0]    OP_MUL = 3'b101;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && (ALUCtrl_i == OP_MUL)) begin
          mcand_d  = data1_i;
          mplier_d = data2_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last iteration: publish the accumulator including this edge's partial product.
        if (cnt_q == LAST) begin
          data_d  = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign data_o = data_q;
  assign Zero_o = (data_q == '0);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random operands
// compared against a plain-arithmetic product model.
module tb_mul_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  ALUCtrl_i = 3'b000;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;
  logic        Zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  mul_unit #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .data_o    (data_o),
    .Zero_o    (Zero_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation; while running, inputs are scrambled and optionally start is re-asserted
  // (also across the DONE cycle) to show neither has any effect.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] exp;
    int n;
    exp = ref_mul(a, b);
    @(negedge clk_i);
    start_i   = 1'b1;
    ALUCtrl_i = 3'b101;
    data1_i   = a;
    data2_i   = b;
    @(negedge clk_i);
    start_i = poke;
    n = 0;
    while (busy_o && n < 50) begin
      check("no_done_while_busy", {63'd0, done_o}, 64'd0);
      data1_i = $urandom;
      data2_i = $urandom;
      if (poke) begin
        data1_i = 32'd9;
        data2_i = 32'd9;
      end
      n++;
      @(negedge clk_i);
    end
    check("busy_cycles", 64'(n), 64'd32);
    check("done_pulse", {63'd0, done_o}, 64'd1);
    check("busy_in_done", {63'd0, busy_o}, 64'd0);
    check("product", {32'd0, data_o}, {32'd0, exp});
    check("zero_flag", {63'd0, Zero_o}, {63'd0, (exp == 32'd0)});
    @(negedge clk_i);
    check("done_single", {63'd0, done_o}, 64'd0);
    check("idle_after_done", {63'd0, busy_o}, 64'd0);
    check("product_held", {32'd0, data_o}, {32'd0, exp});
    start_i = 1'b0;
  endtask

  initial begin
    int prev_busy, nacc, last_idx;
    logic [31:0] a, b;

    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_data", {32'd0, data_o}, 64'd0);
    check("rst_zero", {63'd0, Zero_o}, 64'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    do_mul(32'd3, 32'd5, 1'b0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_mul(32'h8000_0000, 32'd2, 1'b0);
    do_mul(32'h0000_1234, 32'd0, 1'b0);
    do_mul(32'd7, 32'd6, 1'b1);

    // Invalid opcode in IDLE is ignored
    @(negedge clk_i);
    start_i   = 1'b1;
    ALUCtrl_i = 3'b010;
    data1_i   = 32'd11;
    data2_i   = 32'd13;
    repeat (4) begin
      @(negedge clk_i);
      check("badop_busy", {63'd0, busy_o}, 64'd0);
      check("badop_done", {63'd0, done_o}, 64'd0);
      check("badop_data", {32'd0, data_o}, 64'd42);
    end
    start_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) b = b & 32'h0000_00FF;
      do_mul(a, b, 1'b0);
    end

    do_mul(32'd6, 32'd7, 1'b0);
    // Reset in the middle of an operation clears everything without a clock edge
    @(negedge clk_i);
    start_i   = 1'b1;
    ALUCtrl_i = 3'b101;
    data1_i   = 32'd10;
    data2_i   = 32'd10;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("mid_busy", {63'd0, busy_o}, 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_done", {63'd0, done_o}, 64'd0);
    check("arst_data", {32'd0, data_o}, 64'd0);
    check("arst_zero", {63'd0, Zero_o}, 64'd1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (30) begin
      @(negedge clk_i);
      check("abort_no_done", {63'd0, done_o}, 64'd0);
    end
    do_mul(32'd4, 32'd4, 1'b0);

    // start held high continuously: a new acceptance every 34 edges
    @(negedge clk_i);
    start_i   = 1'b1;
    ALUCtrl_i = 3'b101;
    data1_i   = 32'd2;
    data2_i   = 32'd3;
    prev_busy = 0;
    nacc      = 0;
    last_idx  = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_i);
      if (busy_o && prev_busy == 0) begin
        if (nacc > 0) check("b2b_period", 64'(i - last_idx), 64'd34);
        last_idx = i;
        nacc++;
      end
      if (done_o) check("b2b_product", {32'd0, data_o}, 64'd6);
      prev_busy = busy_o ? 1 : 0;
    end
    check("b2b_count", 64'(nacc), 64'd4);
    start_i = 1'b0;
    repeat (40) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_i  input  1  reset; asynchronous, active-low.
REQ-004 Port: start_i  input  1  request to begin an operation.
REQ-005 Port: ALUCtrl_i  input  3  operation code; only 3'b101 (multiply) is valid.
REQ-006 Port: data1_i  input  WIDTH  multiplicand.
REQ-007 Port: data2_i  input  WIDTH  multiplier.
REQ-008 Port: busy_o  output  1  high while an operation is in progress.
REQ-009 Port: done_o  output  1  one-cycle pulse; data_o is valid from this cycle onward.
REQ-010 Port: data_o  output  WIDTH  low WIDTH bits of the product; held until the next completion.
REQ-011 Port: Zero_o  output  1  high when data_o == 0.

Function
REQ-012 The block SHALL be an iterative shift-add multiplier with three states: IDLE, RUN and DONE.
REQ-013 IDLE: when start_i=1 and ALUCtrl_i=3'b101 at an edge, the block SHALL latch data1_i into the multiplicand register and data2_i into the multiplier register, clear the accumulator and the iteration counter, and go to RUN.
REQ-014 IDLE: when start_i=1 with any other ALUCtrl_i, the block SHALL ignore the request; state and outputs stay unchanged.
REQ-015 RUN, each edge: if multiplier[0]=1, then acc <= acc + multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-016 RUN SHALL last exactly WIDTH edges. No early termination: latency is fixed regardless of operand values.
REQ-017 On the WIDTH-th RUN edge, the block SHALL load data_o with the final accumulator value and go to DONE.
REQ-018 DONE SHALL last one cycle, with done_o=1 and busy_o=0. It SHALL then return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge E0 gives done_o high in the cycle after edge E(WIDTH), i.e. between E32 and E33 for WIDTH=32.
REQ-020 busy_o SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-021 start_i asserted in RUN or DONE SHALL be ignored; it is neither queued nor allowed to alter operands. The earliest next acceptance is the first edge in IDLE.
REQ-022 data1_i and data2_i SHALL be sampled only at acceptance; changes during RUN have no effect.
REQ-023 Product SHALL be the low WIDTH bits of the unsigned product. This is also the correct two's-complement low half, so no sign handling is required.
REQ-024 Zero_o SHALL be derived combinationally from data_o.
REQ-025 data_o SHALL change only on the WIDTH-th RUN edge and on reset.
REQ-026 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-027 rst_i=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, busy_o=0, done_o=0, data_o=0 (so Zero_o=1), and clear the accumulator, counter and operand registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done_o pulse. After release, the block SHALL accept a new start on the first edge.
REQ-029 Reset release SHALL be synchronised externally; the block needs no internal synchroniser.

Verification
REQ-030 Basic multiply: data1=3, data2=5, ALUCtrl=101, start for 1 cycle -> busy_o for 32 cycles, then a single done_o pulse with data_o=15 and Zero_o=0.
REQ-031 Wrap-around: 0xFFFFFFFF x 0xFFFFFFFF -> data_o=0x00000001. Also 0x80000000 x 2 -> data_o=0, Zero_o=1.
REQ-032 Zero operand: data1=0x1234, data2=0 -> latency still 32 cycles, data_o=0, Zero_o=1.
REQ-033 Ignored start: start with 7x6 accepted; during RUN, assert start with 9x9 and change data1/data2 -> one done_o only, data_o=42. Also start with ALUCtrl=010 in IDLE -> busy_o stays 0.
REQ-034 Reset mid-op: start 10x10, assert rst_i=0 after 10 cycles -> all outputs clear immediately, no done_o. Then release reset and start 4x4 -> data_o=16 after 32 cycles.
REQ-035 Back-to-back: start held high continuously with 2x3 -> acceptances occur every 34 edges (RUN 32 + DONE 1 + IDLE 1), each yielding data_o=6.
